// File: rtl/fadd_sequencer.sv
// Control FSM for the single-precision float adder datapath: latches an operand pair,
// steps align -> add -> normalize -> round, and returns the packed result over valid/ready.
module fadd_sequencer #(
  parameter int MAX_STAGE_CYC = 32,
  parameter int MAX_RENORM    = 2
) (
  input  logic        clk,
  input  logic        res,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] opa_q,
  output logic [31:0] opb_q,
  output logic        align_en,
  input  logic        align_done,
  output logic        add_en,
  output logic        norm_en,
  input  logic        norm_done,
  output logic        round_en,
  input  logic        round_carry,
  input  logic        exp_ovf,
  input  logic [31:0] round_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic        err,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, so the two never overlap.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    RCHK  = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int          RN_W       = (MAX_RENORM > 1) ? $clog2(MAX_RENORM) : 1;
  localparam logic [5:0]  STAGE_LAST = 6'(MAX_STAGE_CYC - 1);
  localparam logic [RN_W-1:0] RN_LAST = RN_W'(MAX_RENORM - 1);
  localparam logic [31:0] QNAN       = 32'h7FC00000;

  state_t            state, state_d;
  logic [31:0]       opa_d, opb_d, result_d;
  logic              ovf_d, err_d;
  logic [5:0]        stage_cnt, stage_d;
  logic [RN_W-1:0]   renorm_cnt, renorm_d;
  logic              a_zero, b_zero;

  assign a_zero = (op_a[30:0] == 31'd0);
  assign b_zero = (op_b[30:0] == 31'd0);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state      <= IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      result     <= '0;
      ovf        <= 1'b0;
      err        <= 1'b0;
      stage_cnt  <= '0;
      renorm_cnt <= '0;
    end else begin
      state      <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      result     <= result_d;
      ovf        <= ovf_d;
      err        <= err_d;
      stage_cnt  <= stage_d;
      renorm_cnt <= renorm_d;
    end
  end

  always_comb begin
    state_d  = state;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result;
    ovf_d    = ovf;
    err_d    = err;
    stage_d  = stage_cnt;
    renorm_d = renorm_cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          opa_d    = op_a;
          opb_d    = op_b;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          renorm_d = '0;
          stage_d  = '0;
          if (a_zero || b_zero) begin
            // Zero operand: the sum is the other operand; -0 only when both are -0.
            state_d = DONE;
            if (a_zero && b_zero) result_d = {op_a[31] & op_b[31], 31'd0};
            else if (a_zero)      result_d = op_b;
            else                  result_d = op_a;
          end else begin
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (align_done) begin
          state_d = ADD;
        end else if (stage_cnt == STAGE_LAST) begin
          err_d    = 1'b1;
          result_d = QNAN;
          state_d  = DONE;
        end else begin
          stage_d = stage_cnt + 6'd1;
        end
      end
      ADD: begin
        stage_d = '0;
        state_d = NORM;
      end
      NORM: begin
        if (norm_done) begin
          state_d = ROUND;
        end else if (stage_cnt == STAGE_LAST) begin
          err_d    = 1'b1;
          result_d = QNAN;
          state_d  = DONE;
        end else begin
          stage_d = stage_cnt + 6'd1;
        end
      end
      ROUND: state_d = RCHK;
      RCHK: begin
        if (exp_ovf) begin
          result_d = {round_result[31], 8'hFF, 23'd0};
          ovf_d    = 1'b1;
          state_d  = DONE;
        end else if (round_carry && (renorm_cnt == RN_LAST)) begin
          err_d    = 1'b1;
          result_d = QNAN;
          state_d  = DONE;
        end else if (round_carry) begin
          renorm_d = renorm_cnt + RN_W'(1);
          stage_d  = '0;
          state_d  = NORM;
        end else begin
          result_d = round_result;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign align_en  = (state == ALIGN);
  assign add_en    = (state == ADD);
  assign norm_en   = (state == NORM);
  assign round_en  = (state == ROUND);
  assign state_dbg = state;

endmodule
